inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage between inst_mem and the cpu decode/execute path.
//  Holds the fetch PC and drives inst_mem's combinational read port.
//  Buffers {pc, instruction} pairs in a small FIFO and hands them downstream with a valid/ready handshake.
//  Accepts a redirect (branch/jump target) that flushes buffered work.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded on reset
//  FIFO_DEPTH  4              buffered entries; power of 2, >= 2
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   reset, synchronous, active-high
//  inst_addr       out  32  byte address to inst_mem; equals fetch_pc register
//  inst_data       in   32  inst_mem read data, valid in the same cycle as inst_addr
//  redirect_valid  in   1   load new fetch PC and flush FIFO
//  redirect_pc     in   32  redirect target (byte address)
//  out_valid       out  1   FIFO head holds an instruction
//  out_ready       in   1   consumer accepts head this cycle
//  out_inst        out  32  head instruction; 32'h0000_0013 (nop) when empty
//  out_pc          out  32  head PC; 32'h0 when empty
//  stall_cycles    out  32  backpressure counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at an edge): fetch_pc<=RESET_PC, FIFO emptied, count<=0; out_valid=0, out_inst=nop, out_pc=0, stall_cycles=0.
//  Reset mid-operation discards all buffered entries. No pop is reported for the reset cycle.
//  inst_addr = fetch_pc, direct from the register with no combinational path from inputs.
//  push = !redirect_valid && (count<FIFO_DEPTH || pop); pushes {fetch_pc, inst_data}; fetch_pc<=fetch_pc+4.
//  pop = out_valid && out_ready; advances head.
//  Latency: an instruction pushed at edge N is visible on out_* in the cycle after edge N.
//   Steady state with out_ready=1: one instruction per cycle, no bubbles.
//  Full: count==FIFO_DEPTH with no pop -> no push, fetch_pc holds.
//   Full with pop -> push and pop in the same cycle; count unchanged.
//  Empty: out_valid=0; out_ready is ignored.
//  Redirect: at the edge, FIFO is flushed (count<=0) and fetch_pc<={redirect_pc[31:2],2'b00}. No push that cycle.
//   A same-cycle pop still counts as accepted by the consumer.
//   Next cycle: out_valid=0, inst_addr=target. Target instruction appears on out_* one cycle later.
//  Simultaneous rst and redirect_valid: rst wins.
//  PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0.
//  Occupancy count is $clog2(FIFO_DEPTH)+1 bits. Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
// CONFIGURATION
//  Macro IFETCH_STALL_CNT_EN:
//   defined: stall_cycles increments every cycle with out_valid=1 && out_ready=0.
//    Saturates at 32'hFFFF_FFFF. Cleared only by rst; a redirect does not clear it.
//   undefined: stall_cycles tied to 32'h0 and no counter logic is built. The port always exists.
// TESTING
//  1 inst_mem[0]=nop, [1]=nop, [2]=32'h03400093; rst 1 cycle, then out_ready=1.
//    -> out_pc 0,4,8 on consecutive cycles starting 1 cycle after fetch begins.
//    -> out_inst 00000013, 00000013, 03400093 in that order.
//  2 out_ready=0 for 10 cycles after reset (FIFO_DEPTH=4).
//    -> FIFO fills with pc 0,4,8,C; inst_addr holds 0x10; out_valid=1.
//    -> then out_ready=1 -> out_pc 0,4,8,C,10,14 with no gap or duplicate.
//  3 FIFO holds 3 entries; redirect_valid=1 with redirect_pc=32'h42 for 1 cycle.
//    -> next cycle out_valid=0 and inst_addr=32'h40.
//    -> following cycle out_pc=32'h40 with out_valid=1.
//  4 RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc FFFFFFF8, FFFFFFFC, 00000000.
//  5 rst asserted for 1 cycle mid-stream with the FIFO full.
//    -> next cycle out_valid=0, out_inst=00000013, inst_addr=RESET_PC.
//  6 valid head with out_ready=0 for 5 cycles.
//    -> stall_cycles=5 with IFETCH_STALL_CNT_EN defined, 0 without it.
//    -> redirect then leaves the value unchanged.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage.
// Holds the fetch PC and drives the combinational inst_mem read port.
// Buffers {pc, instruction} pairs in a small FIFO and delivers them
// downstream with a valid/ready handshake. A redirect reloads the fetch PC
// and flushes all buffered entries.
// Optional build macro IFETCH_STALL_CNT_EN enables the saturating
// backpressure counter on stall_cycles. When the macro is undefined, the
// port is tied to zero.

module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] stall_cycles
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_buf   [FIFO_DEPTH];
    logic [31:0]   inst_buf [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Redirect targets are word aligned, so the low bits of redirect_pc are dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = &redirect_pc[1:0];

    assign inst_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // count never exceeds the depth, so "not full" is the same as count < depth.
    assign push      = !redirect_valid && ((count != DEPTH_C) || pop);
    assign out_inst  = out_valid ? inst_buf[rd_ptr] : NOP;
    assign out_pc    = out_valid ? pc_buf[rd_ptr]   : 32'h0;

    // Fetch PC, FIFO pointers and occupancy; reset beats redirect, and redirect beats push.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_buf[wr_ptr]   <= fetch_pc;
            inst_buf[wr_ptr] <= inst_data;
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count cycles where a valid head is held off by the consumer; saturate and survive redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: reset state, streaming, full FIFO
// with backpressure, redirect flush, PC wrap, mid-stream reset, and the
// stall counter. The bench checks the stall counter against the build
// configuration it was compiled with.

module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr, inst_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst, out_pc, stall_cycles;

    logic [31:0] inst_addr_hi, inst_data_hi, out_inst_hi, out_pc_hi, stall_hi;
    logic        out_valid_hi;

    logic [31:0] imem [64];
    int n_cmp = 0;
    int n_err = 0;

`ifdef IFETCH_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL5 = 32'd5;
`else
    localparam logic [31:0] EXP_STALL5 = 32'd0;
`endif

    always #5 clk = ~clk;

    always_comb inst_data    = imem[inst_addr[7:2]];
    always_comb inst_data_hi = imem[inst_addr_hi[7:2]];

    inst_fetch dut (
        .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .stall_cycles(stall_cycles)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_hi (
        .clk(clk), .rst(rst), .inst_addr(inst_addr_hi), .inst_data(inst_data_hi),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid_hi), .out_ready(1'b1), .out_inst(out_inst_hi),
        .out_pc(out_pc_hi), .stall_cycles(stall_hi)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 + i;
        imem[0] = 32'h0000_0013;
        imem[1] = 32'h0000_0013;
        imem[2] = 32'h0340_0093;

        // Streaming after reset, plus the high-reset-PC instance wrapping.
        rst = 1'b1; out_ready = 1'b1;
        step();
        check("rst_valid",  {31'h0, out_valid}, 32'h0);
        check("rst_inst",   out_inst, 32'h0000_0013);
        check("rst_pc",     out_pc, 32'h0);
        check("rst_stall",  stall_cycles, 32'h0);
        check("rst_addr",   inst_addr, 32'h0);
        check("hi_addr",    inst_addr_hi, 32'hFFFF_FFF8);
        rst = 1'b0;
        step();
        check("s1_pc0",   out_pc, 32'h0);
        check("s1_inst0", out_inst, 32'h0000_0013);
        check("wrap_pc0", out_pc_hi, 32'hFFFF_FFF8);
        step();
        check("s1_pc1",   out_pc, 32'h4);
        check("s1_inst1", out_inst, 32'h0000_0013);
        check("wrap_pc1", out_pc_hi, 32'hFFFF_FFFC);
        step();
        check("s1_pc2",   out_pc, 32'h8);
        check("s1_inst2", out_inst, 32'h0340_0093);
        check("wrap_pc2", out_pc_hi, 32'h0);

        // Fill under backpressure, then drain with no gap or duplicate.
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full_addr",  inst_addr, 32'h10);
        check("full_valid", {31'h0, out_valid}, 32'h1);
        check("full_pc",    out_pc, 32'h0);
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("drain_pc", out_pc, 32'(i * 4));
        end
        check("drain_inst", out_inst, 32'hA000_0005);

        // Redirect with three entries buffered.
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        check("pre_redir_addr", inst_addr, 32'hC);
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("redir_valid", {31'h0, out_valid}, 32'h0);
        check("redir_addr",  inst_addr, 32'h40);
        step();
        check("redir_tvalid", {31'h0, out_valid}, 32'h1);
        check("redir_tpc",    out_pc, 32'h40);
        check("redir_tinst",  out_inst, 32'hA000_0010);

        // Reset while full.
        for (int i = 0; i < 5; i++) step();
        check("midrst_full_addr", inst_addr, 32'h50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_inst",  out_inst, 32'h0000_0013);
        check("midrst_addr",  inst_addr, 32'h0);

        // Reset and redirect in the same cycle: reset wins.
        step(); step();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        rst = 1'b0; redirect_valid = 1'b0;
        check("rst_beats_redir", inst_addr, 32'h0);

        // Stall counter: five held cycles, then a redirect leaves it alone.
        out_ready = 1'b0;
        step();
        check("stall_first_valid", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) step();
        check("stall_5", stall_cycles, EXP_STALL5);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("stall_after_redir", stall_cycles, EXP_STALL5);
        step();
        check("stall_hold", stall_cycles, EXP_STALL5);
        check("stall_hi_zero", stall_hi, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
